// File: rtl/cordic_pkg.sv
// Shared constants, atan table and FSM state type for the iterative CORDIC vectoring controller.
package cordic_pkg;

  localparam logic [31:0] ANGLE_180  = 32'h8000_0000;
  localparam logic [31:0] ANGLE_22P5 = 32'h1000_0000;

  // atan(2^-i) scaled so that a full circle is 2^32
  localparam logic [31:0] ATAN [16] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D
  };

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_e;

  function automatic logic [31:0] atan_lookup(input logic [3:0] idx);
    return ATAN[idx];
  endfunction

endpackage

// File: rtl/cordic_micro_rot.sv
// One CORDIC vectoring micro-rotation: drives y toward zero, accumulating the rotated angle in z.
module cordic_micro_rot #(
  parameter int unsigned Width = 13
) (
  input  logic [Width-1:0] x_i,
  input  logic [Width-1:0] y_i,
  input  logic [31:0]      z_i,
  input  logic [3:0]       shift_i,
  input  logic [31:0]      atan_i,
  output logic [Width-1:0] x_o,
  output logic [Width-1:0] y_o,
  output logic [31:0]      z_o
);

  logic signed [Width-1:0] x_s, y_s, x_sh, y_sh;

  assign x_s  = x_i;
  assign y_s  = y_i;
  assign x_sh = x_s >>> shift_i;
  assign y_sh = y_s >>> shift_i;

  always_comb begin
    if (!y_s[Width-1]) begin
      x_o = x_s + y_sh;
      y_o = y_s - x_sh;
      z_o = z_i + atan_i;
    end else begin
      x_o = x_s - y_sh;
      y_o = y_s + x_sh;
      z_o = z_i - atan_i;
    end
  end

endmodule

// File: rtl/cordic_iter_ctrl.sv
// Time-multiplexed CORDIC vectoring controller: magnitude (gain K uncompensated), phase and
// NMS direction sector for one Sobel gradient pair per transaction.
module cordic_iter_ctrl
  import cordic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_IN = 11,
  parameter int unsigned ITERATIONS    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH_IN-1:0] gx,
  input  logic [DATA_WIDTH_IN-1:0] gy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH_IN+1:0] mag_out,
  output logic [31:0]              angle_out,
  output logic [1:0]               sector_out
);

  localparam int unsigned Width    = DATA_WIDTH_IN + 2;
  localparam logic [4:0]  LastIter = 5'(ITERATIONS - 1);

  state_e           state_q, state_d;
  logic [4:0]       i_q, i_d;
  logic [Width-1:0] x_q, x_d, y_q, y_d;
  logic [31:0]      z_q, z_d;
  logic             zero_q, zero_d;

  logic [Width-1:0] gx_ext, gy_ext;
  logic [Width-1:0] x_rot, y_rot;
  logic [31:0]      z_rot;

  assign gx_ext = {{2{gx[DATA_WIDTH_IN-1]}}, gx};
  assign gy_ext = {{2{gy[DATA_WIDTH_IN-1]}}, gy};

  cordic_micro_rot #(
    .Width (Width)
  ) u_micro_rot (
    .x_i     (x_q),
    .y_i     (y_q),
    .z_i     (z_q),
    .shift_i (i_q[3:0]),
    .atan_i  (atan_lookup(i_q[3:0])),
    .x_o     (x_rot),
    .y_o     (y_rot),
    .z_o     (z_rot)
  );

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Fold the left half-plane onto the right so vectoring always converges
          if (gx[DATA_WIDTH_IN-1]) begin
            x_d = -gx_ext;
            y_d = -gy_ext;
            z_d = ANGLE_180;
          end else begin
            x_d = gx_ext;
            y_d = gy_ext;
            z_d = '0;
          end
          zero_d  = (gx == '0) && (gy == '0);
          i_d     = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        x_d = x_rot;
        y_d = y_rot;
        z_d = z_rot;
        if (i_q == LastIter) begin
          state_d = DONE;
        end else begin
          i_d = i_q + 5'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
    end
  end

  logic        show_result;
  logic [30:0] sector_sum;

  // Reset masks the handshake outputs combinationally so an aborted DONE never pulses
  assign in_ready    = (state_q == IDLE) || rst;
  assign out_valid   = (state_q == DONE) && !rst;
  assign show_result = out_valid && !zero_q;
  assign mag_out     = show_result ? x_q : '0;
  assign angle_out   = show_result ? z_q : '0;

  // Fold to 0..180 degrees, offset by 22.5 degrees, then the top two bits pick the sector
  assign sector_sum  = angle_out[30:0] + ANGLE_22P5[30:0];
  assign sector_out  = sector_sum[30:29];

endmodule
